// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with a blocking miss FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
    parameter int unsigned LINES  = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned IW    = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 5 - IW;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StRefill} stateE;

    stateE              stateQ;
    logic [LINES-1:0]   validQ;
    logic [LINES-1:0]   dirtyQ;
    logic               memEnableQ;
    logic               memWriteQ;
    logic [31:0]        memAddrQ;
    logic [LINE_W-1:0]  memDataQ;
    logic [31:0]        rdataQ;

    logic [TAG_W-1:0]   tagArr  [LINES];
    logic [LINE_W-1:0]  dataArr [LINES];

    logic [TAG_W-1:0]   addrTag;
    logic [IW-1:0]      idx;
    logic [2:0]         wordSel;
    logic [TAG_W-1:0]   curTag;
    logic [LINE_W-1:0]  curLine;
    logic [31:0]        curWord;
    logic               hit;
    logic               idleHit;
    logic               idleMiss;
    logic               unusedAddr;

    assign addrTag    = addr_i[31:5+IW];
    assign idx        = addr_i[4+IW:5];
    assign wordSel    = addr_i[4:2];
    assign unusedAddr = ^addr_i[1:0];

    assign curTag   = tagArr[idx];
    assign curLine  = dataArr[idx];
    assign curWord  = curLine[{wordSel, 5'b00000} +: 32];

    assign hit      = req_i & validQ[idx] & (curTag == addrTag);
    assign idleHit  = (stateQ == StIdle) & hit;
    assign idleMiss = (stateQ == StIdle) & req_i & ~hit;

    // Stall is forced low while reset is held so the pipeline is released at once.
    assign stall_o      = ~rst_i & ((stateQ != StIdle) | idleMiss);
    assign rdata_o      = (idleHit & ~write_i) ? curWord : rdataQ;
    assign mem_enable_o = memEnableQ;
    assign mem_write_o  = memWriteQ;
    assign mem_addr_o   = memAddrQ;
    assign mem_data_o   = memDataQ;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateQ     <= StIdle;
            validQ     <= '0;
            dirtyQ     <= '0;
            memEnableQ <= 1'b0;
            memWriteQ  <= 1'b0;
            memAddrQ   <= '0;
            memDataQ   <= '0;
            rdataQ     <= '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (idleHit) begin
                        if (write_i) begin
                            dirtyQ[idx] <= 1'b1;
                        end else begin
                            rdataQ <= curWord;
                        end
                    end else if (idleMiss) begin
                        memEnableQ <= 1'b1;
                        if (validQ[idx] && dirtyQ[idx]) begin
                            stateQ    <= StWriteback;
                            memWriteQ <= 1'b1;
                            memAddrQ  <= {curTag, idx, 5'b00000};
                            memDataQ  <= curLine;
                        end else begin
                            stateQ    <= StAllocate;
                            memWriteQ <= 1'b0;
                            memAddrQ  <= {addrTag, idx, 5'b00000};
                        end
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) begin
                        stateQ    <= StAllocate;
                        memWriteQ <= 1'b0;
                        memAddrQ  <= {addrTag, idx, 5'b00000};
                    end
                end
                StAllocate: begin
                    if (mem_ack_i) begin
                        stateQ      <= StRefill;
                        memEnableQ  <= 1'b0;
                        validQ[idx] <= 1'b1;
                        dirtyQ[idx] <= 1'b0;
                    end
                end
                StRefill: begin
                    stateQ <= StIdle;
                end
                default: begin
                    stateQ <= StIdle;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; validQ alone gates their use.
    always_ff @(posedge clk_i) begin
        if (idleHit && write_i) begin
            dataArr[idx][{wordSel, 5'b00000} +: 32] <= wdata_i;
        end
        if ((stateQ == StAllocate) && mem_ack_i) begin
            dataArr[idx] <= mem_data_i;
            tagArr[idx]  <= addrTag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        afterRefillQ;
    logic [31:0] hitCntQ;
    logic [31:0] missCntQ;

    // The hit that completes a refilled access belongs to the miss already counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            afterRefillQ <= 1'b0;
            hitCntQ      <= '0;
            missCntQ     <= '0;
        end else begin
            afterRefillQ <= (stateQ == StRefill);
            if (idleHit && !afterRefillQ && (hitCntQ != 32'hFFFF_FFFF)) begin
                hitCntQ <= hitCntQ + 32'd1;
            end
            if (idleMiss && (missCntQ != 32'hFFFF_FFFF)) begin
                missCntQ <= missCntQ + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hitCntQ;
    assign miss_cnt_o = missCntQ;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, reset and
// spurious-ack sequences, then random accesses against a line-level cache model.
module tb_dcache_controller;

    logic         clk;
    logic         rst;
    logic         req;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         memEn;
    logic         memWr;
    logic [31:0]  memAddr;
    logic [255:0] memDataOut;
    logic [255:0] memRdata;
    logic         ack;
    logic         spuriousAck;
    logic         memAck;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hitCnt;
    logic [31:0]  missCnt;
`endif

    assign memAck = ack | spuriousAck;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .write_i      (write),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .stall_o      (stall),
        .mem_enable_o (memEn),
        .mem_write_o  (memWr),
        .mem_addr_o   (memAddr),
        .mem_data_o   (memDataOut),
        .mem_data_i   (memRdata),
        .mem_ack_i    (memAck)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hitCnt),
        .miss_cnt_o   (missCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- off-chip memory model ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  a;
        logic [255:0] d;
    } txnT;

    txnT          memLog [$];
    logic [255:0] memStore [logic [26:0]];
    int           ackWait = 1;
    int           memCnt  = 0;

    function automatic logic [255:0] defaultLine(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA500_0000 ^ (la + 32'(k * 4));
        return l;
    endfunction

    function automatic logic [255:0] readLine(input logic [31:0] a);
        if (memStore.exists(a[31:5])) return memStore[a[31:5]];
        return defaultLine({a[31:5], 5'b00000});
    endfunction

    // Acks in the ackWait-th cycle that a request has been held.
    always @(posedge clk) begin
        txnT t;
        #1;
        ack = 1'b0;
        if (rst) begin
            memCnt = 0;
        end else if (memEn) begin
            memCnt++;
            if (memCnt >= ackWait) begin
                ack    = 1'b1;
                memCnt = 0;
                t.wr = memWr;
                t.a  = memAddr;
                t.d  = memDataOut;
                memLog.push_back(t);
                if (memWr) memStore[memAddr[31:5]] = memDataOut;
                else memRdata = readLine(memAddr);
            end
        end else begin
            memCnt = 0;
        end
    end

    // ---------------- access driver ----------------
    task automatic doAccess(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int w, output int stalls, output logic [31:0] rd,
                            output bit timedOut);
        ackWait = w;
        memLog.delete();
        @(posedge clk); #1;
        req = 1'b1; write = wr; addr = a; wdata = wd;
        stalls = 0;
        timedOut = 1'b0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 300) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        rd = rdata;
        @(posedge clk); #1;
        req = 1'b0; write = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          w;
        int          expStall;
        logic        chkRd;
        logic [31:0] expRd;
        logic        expWb;
        logic [31:0] wbAddr;
        logic [31:0] wbW1;
        logic        expFetch;
        logic [31:0] fetchAddr;
    } vecT;

    vecT vecs [10];

    // ---------------- reference cache model ----------------
    logic         mValid [32];
    logic         mDirty [32];
    logic [21:0]  mTag   [32];
    logic [255:0] mLine  [32];
    int           mHit;
    int           mMiss;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           st;
        logic [31:0]  rd;
        bit           to;
        int           nExp;
        int           j;
        logic [255:0] l40;
        logic [31:0]  lastRd;

        rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        memRdata = '0; spuriousAck = 1'b0; ack = 1'b0;

        l40 = defaultLine(32'h40);
        l40[31:0] = 32'hDEAD_BEEF;
        memStore[27'h2] = l40;

        //          wr    addr          wdata         w   st  chkRd expRd         wb    wbAddr  wbW1          f     fAddr
        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,        10, 12, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,  32'h0,        1'b1, 32'h40};
        vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,        1,  0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 1,  0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0044, 32'h0,        1,  0,  1'b1, 32'h1234_5678, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0440, 32'h0,        3,  8,  1'b1, 32'hA500_0440, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 32'h440};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,        2,  4,  1'b1, 32'h1234_5678, 1'b0, 32'h0,  32'h0,        1'b1, 32'h40};
        vecs[6] = '{1'b1, 32'h0000_0880, 32'h0BAD_F00D, 4,  6,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,        1'b1, 32'h880};
        vecs[7] = '{1'b0, 32'h0000_0880, 32'h0,        1,  0,  1'b1, 32'h0BAD_F00D, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0884, 32'h0,        1,  0,  1'b1, 32'hA500_0884, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[9] = '{1'b1, 32'h0000_0044, 32'h55AA_55AA, 1,  0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h0,        1'b0, 32'h0};

        #1;
        chk("reset stall", 256'(stall), 256'd0);
        chk("reset memEn", 256'(memEn), 256'd0);
        chk("reset memWr", 256'(memWr), 256'd0);
        chk("reset memAddr", 256'(memAddr), 256'd0);
        chk("reset memData", memDataOut, 256'd0);
        chk("reset rdata", 256'(rdata), 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            doAccess(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].w, st, rd, to);
            chk($sformatf("v%0d timeout", i), 256'(to), 256'd0);
            chk($sformatf("v%0d stall cycles", i), 256'(st), 256'(vecs[i].expStall));
            if (vecs[i].chkRd) chk($sformatf("v%0d rdata", i), 256'(rd), 256'(vecs[i].expRd));
            nExp = int'(vecs[i].expWb) + int'(vecs[i].expFetch);
            chk($sformatf("v%0d mem txns", i), 256'(memLog.size()), 256'(nExp));
            if (memLog.size() == nExp) begin
                j = 0;
                if (vecs[i].expWb) begin
                    chk($sformatf("v%0d wb write", i), 256'(memLog[0].wr), 256'd1);
                    chk($sformatf("v%0d wb addr", i), 256'(memLog[0].a), 256'(vecs[i].wbAddr));
                    chk($sformatf("v%0d wb word1", i), 256'(memLog[0].d[63:32]),
                        256'(vecs[i].wbW1));
                    j = 1;
                end
                if (vecs[i].expFetch) begin
                    chk($sformatf("v%0d fetch write", i), 256'(memLog[j].wr), 256'd0);
                    chk($sformatf("v%0d fetch addr", i), 256'(memLog[j].a),
                        256'(vecs[i].fetchAddr));
                end
            end
        end

        // Ack pulse with no request outstanding must not disturb the cache.
        @(posedge clk); #1;
        memRdata = {8{32'hFFFF_0000}};
        spuriousAck = 1'b1;
        @(posedge clk); #1;
        spuriousAck = 1'b0;
        doAccess(1'b0, 32'h0000_0880, 32'h0, 1, st, rd, to);
        chk("spurious ack stall", 256'(st), 256'd0);
        chk("spurious ack rdata", 256'(rd), 256'h0BAD_F00D);

        // Reset in the middle of writing back the dirty 0x880 line.
        ackWait = 20;
        memLog.delete();
        @(posedge clk); #1;
        req = 1'b1; write = 1'b0; addr = 32'h0000_1880;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wb wait memEn", 256'(memEn), 256'd1);
        chk("wb wait memWr", 256'(memWr), 256'd1);
        chk("wb wait addr", 256'(memAddr), 256'h880);
        chk("wb wait stall", 256'(stall), 256'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst memEn", 256'(memEn), 256'd0);
        chk("midrst stall", 256'(stall), 256'd0);
        chk("midrst memAddr", 256'(memAddr), 256'd0);
        chk("midrst rdata", 256'(rdata), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        chk("midrst no txn", 256'(memLog.size()), 256'd0);

        // Line 2 was dirty with 0x55AA55AA; reset must drop it without writeback.
        doAccess(1'b0, 32'h0000_0440, 32'h0, 2, st, rd, to);
        chk("post rst 440 stall", 256'(st), 256'd4);
        chk("post rst 440 txns", 256'(memLog.size()), 256'd1);
        chk("post rst 440 rdata", 256'(rd), 256'hA500_0440);
        doAccess(1'b0, 32'h0000_0044, 32'h0, 2, st, rd, to);
        chk("post rst 44 stall", 256'(st), 256'd4);
        chk("post rst 44 rdata", 256'(rd), 256'h1234_5678);

        // ---------------- random phase ----------------
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i]   = '0;
            mLine[i]  = '0;
        end
        mHit = 0;
        mMiss = 0;
        lastRd = '0;

        for (int n = 0; n < 300; n++) begin
            int           li;
            int           tg;
            int           ws;
            int           w;
            logic         wr;
            logic [31:0]  wd;
            logic [31:0]  a;
            logic         hitExp;
            logic         wbExp;
            logic [31:0]  wbA;
            logic [255:0] wbD;
            logic [255:0] newLine;
            int           expSt;

            li = $urandom_range(0, 3);
            tg = $urandom_range(0, 3);
            ws = $urandom_range(0, 7);
            w  = $urandom_range(1, 5);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            a  = {22'(tg), 5'(li), 3'(ws), 2'($urandom_range(0, 3))};

            hitExp = mValid[li] && (mTag[li] == 22'(tg));
            wbExp = 1'b0;
            wbA = '0;
            wbD = '0;
            newLine = '0;
            expSt = 0;
            if (!hitExp) begin
                wbExp = mValid[li] && mDirty[li];
                wbA = {mTag[li], 5'(li), 5'b00000};
                wbD = mLine[li];
                newLine = readLine(a);
                expSt = (wbExp ? w : 0) + w + 2;
                mMiss++;
            end else begin
                mHit++;
            end

            doAccess(wr, a, wd, w, st, rd, to);
            chk($sformatf("r%0d timeout", n), 256'(to), 256'd0);
            chk($sformatf("r%0d stall cycles", n), 256'(st), 256'(expSt));
            nExp = hitExp ? 0 : (wbExp ? 2 : 1);
            chk($sformatf("r%0d mem txns", n), 256'(memLog.size()), 256'(nExp));
            if (memLog.size() == nExp && nExp > 0) begin
                if (wbExp) begin
                    chk($sformatf("r%0d wb addr", n), 256'(memLog[0].a), 256'(wbA));
                    chk($sformatf("r%0d wb data", n), memLog[0].d, wbD);
                end
                chk($sformatf("r%0d fetch write", n), 256'(memLog[nExp-1].wr), 256'd0);
                chk($sformatf("r%0d fetch addr", n), 256'(memLog[nExp-1].a),
                    256'({a[31:5], 5'b00000}));
            end

            if (!hitExp) begin
                mValid[li] = 1'b1;
                mTag[li]   = 22'(tg);
                mLine[li]  = newLine;
                mDirty[li] = 1'b0;
            end
            if (wr) begin
                mLine[li][ws*32 +: 32] = wd;
                mDirty[li] = 1'b1;
            end else begin
                lastRd = mLine[li][ws*32 +: 32];
                chk($sformatf("r%0d rdata", n), 256'(rd), 256'(lastRd));
            end

            @(negedge clk);
            chk($sformatf("r%0d idle stall", n), 256'(stall), 256'd0);
            chk($sformatf("r%0d idle rdata hold", n), 256'(rdata), 256'(lastRd));
        end

`ifdef DCACHE_STATS_EN
        chk("hit count", 256'(hitCnt), 256'(mHit));
        chk("miss count", 256'(missCnt), 256'(mMiss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and a slow off-chip data memory.
- Services 32-bit word loads and stores from the MEM stage. Raises a stall to the whole pipeline on a miss.
- Moves whole cache lines to and from memory over a level-held enable/ack handshake.

Parameters:
- LINES, 32, number of cache lines; power of two; index width IW = log2(LINES).
- LINE_W, 256, line width in bits; fixed 8 words × 32 bits; byte offset width 5.
- TAG_W, 32-5-IW (22 at default), tag width; derived, not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  MEM stage access valid (MemRead or MemWrite).
- write_i  in  1  1 = store, 0 = load; sampled only when req_i=1.
- addr_i  in  32  byte address; [1:0] ignored; [4:2] word select; [4+IW:5] index; [31:5+IW] tag.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid in a cycle with req_i=1, write_i=0, stall_o=0.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_enable_o  out  1  memory request, held until ack.
- mem_write_o  out  1  1 = line writeback, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address; [4:0] always 0.
- mem_data_o  out  256  writeback line data.
- mem_data_i  in  256  fetched line data; valid in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset, asynchronous, effective immediately, including mid-transaction:
  - all valid and dirty bits cleared; FSM to IDLE.
  - stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, rdata_o=0.
  - Dirty data is discarded; tag and data arrays need not be cleared.
- Lookup is combinational in IDLE: hit = req_i & valid[idx] & (tag[idx]==addr tag).
- Read hit: rdata_o = selected word in the same cycle; stall_o=0; zero added latency.
- Write hit: at the clock edge, the selected word is replaced by wdata_i and dirty[idx] is set; stall_o=0.
- req_i=0: stall_o=0; rdata_o holds its last value; no state change.
- Miss (req_i & !hit in IDLE): stall_o=1 combinationally in that same cycle. Next state is WRITEBACK if valid & dirty, else ALLOCATE.
- FSM states IDLE, WRITEBACK, ALLOCATE, REFILL:
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag, idx, 5'b0}, mem_data_o=line. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={addr tag, idx, 5'b0}. On mem_ack_i: line ← mem_data_i, tag ← addr tag, valid=1, dirty=0; go to REFILL.
  - REFILL: one cycle with stall_o=1 and mem_enable_o=0; go to IDLE, where the access re-evaluates as a hit and completes.
- Outputs in IDLE and REFILL: mem_enable_o=0; mem_addr_o and mem_data_o hold their last values.
- stall_o=1 in every non-IDLE state.
- Miss latency = writeback ack wait (dirty only) + fetch ack wait + 2 cycles.
- mem_ack_i while mem_enable_o=0 is ignored.
- mem_enable_o deasserts on the cycle after the ack edge; no back-to-back request without a state change.
- addr_i, write_i and wdata_i are held stable by the stalled pipeline during a miss; they are not re-latched.
- Store miss: line fetched first, then the store merges as a write hit in IDLE, leaving dirty=1.
- Index wrap: addresses differing only in tag map to the same line; each access evicts the other (conflict miss).

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0], both reset to 0.
  - hit_cnt_o increments once per completed access whose first IDLE evaluation hit.
  - miss_cnt_o increments once per miss detection in IDLE; a refill's final hit cycle does not count as a hit.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold read 0x0000_0040, memory returns line with word0=0xDEAD_BEEF, ack after 10 cycles -> one fetch at 0x40, mem_write_o=0, stall_o high 12 cycles, rdata_o=0xDEAD_BEEF.
- Re-read 0x40, then store 0x1234_5678 to 0x44 -> no stall, no mem_enable_o, dirty[2]=1; load 0x44 returns 0x1234_5678.
- Read 0x0000_0440 (same index 2, new tag) -> writeback at 0x40 with mem_data_o[63:32]=0x1234_5678, then fetch at 0x440; dirty[2]=0 afterward.
- Store miss to 0x0000_0880 on a clean line -> no writeback, fetch 0x880, word0=wdata_i, dirty=1, total stall = fetch wait + 2.
- Assert rst_i during the WRITEBACK wait -> mem_enable_o=0 and stall_o=0 immediately; next read of 0x440 misses.
- DCACHE_STATS_EN: 3 hits + 2 misses -> hit_cnt_o=3, miss_cnt_o=2; counters preset to 0xFFFF_FFFF stay saturated.
